// File: rtl/multi_port_instr_buffer.sv
// In-order instruction queue between IF1 and ID: up to PUSH_N entries in and
// up to POP_N entries out per cycle, with flush, occupancy and error pulses.
module instr_buf_pop_lane #(
  parameter int DATA_WD = 64,
  parameter int CNT_W   = 5,
  parameter int LANE    = 0
) (
  input  logic [CNT_W-1:0]   count,
  input  logic [DATA_WD-1:0] entry,
  output logic               valid,
  output logic [DATA_WD-1:0] data
);
  assign valid = count > CNT_W'(LANE);
  assign data  = valid ? entry : '0;
endmodule

module multi_port_instr_buffer #(
  parameter int DATA_WD = 64,
  parameter int DEPTH   = 16,
  parameter int PUSH_N  = 4,
  parameter int POP_N   = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PSH_W  = $clog2(PUSH_N + 1),
  localparam int POP_W  = $clog2(POP_N + 1)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           flush,
  input  logic [PUSH_N-1:0][DATA_WD-1:0] push_data,
  input  logic [PSH_W-1:0]               push_num,
  input  logic [POP_W-1:0]               pop_num,
  output logic [POP_N-1:0][DATA_WD-1:0]  pop_data,
  output logic [POP_N-1:0]               pop_valid,
  output logic [CNT_W-1:0]               count,
  output logic [CNT_W-1:0]               free_slots,
  output logic                           empty,
  output logic                           full,
  output logic                           overflow,
  output logic                           underflow
);
  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   push_amt, pop_amt;
  logic               push_ok, pop_ok, push_bad, pop_bad;
  logic [POP_N-1:0][DATA_WD-1:0] lane_entry;

  assign free_slots = CNT_W'(DEPTH) - count;
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

  // Push is judged against pre-pop free space, so push and pop regions never overlap.
  assign push_bad = !flush && (CNT_W'(push_num) > free_slots);
  assign pop_bad  = !flush && (CNT_W'(pop_num) > count);
  assign push_ok  = !flush && !push_bad;
  assign pop_ok   = !flush && !pop_bad;
  assign push_amt = push_ok ? CNT_W'(push_num) : '0;
  assign pop_amt  = pop_ok  ? CNT_W'(pop_num)  : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      head      <= head + PTR_W'(pop_amt);
      tail      <= tail + PTR_W'(push_amt);
      count     <= count + push_amt - pop_amt;
      overflow  <= push_bad;
      underflow <= pop_bad;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < PUSH_N; i++)
      if (push_ok && (i < int'(push_num)))
        mem[tail + PTR_W'(i)] <= push_data[i];
  end

  for (genvar g = 0; g < POP_N; g++) begin : g_pop
    assign lane_entry[g] = mem[head + PTR_W'(g)];
    instr_buf_pop_lane #(.DATA_WD(DATA_WD), .CNT_W(CNT_W), .LANE(g)) u_lane (
      .count (count),
      .entry (lane_entry[g]),
      .valid (pop_valid[g]),
      .data  (pop_data[g])
    );
  end
endmodule

// File: tb/tb_multi_port_instr_buffer.sv
// Bench for multi_port_instr_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_multi_port_instr_buffer;
  localparam int DW = 64, DEPTH = 16, PUSH_N = 4, POP_N = 2;

  logic                      aclk = 1'b0;
  logic                      aresetn = 1'b0;
  logic                      flush = 1'b0;
  logic [PUSH_N-1:0][DW-1:0] push_data = '0;
  logic [2:0]                push_num = '0;
  logic [1:0]                pop_num = '0;
  logic [POP_N-1:0][DW-1:0]  pop_data;
  logic [POP_N-1:0]          pop_valid;
  logic [4:0]                count, free_slots;
  logic                      empty, full, overflow, underflow;

  int tests = 0, fails = 0;

  multi_port_instr_buffer #(.DATA_WD(DW), .DEPTH(DEPTH), .PUSH_N(PUSH_N), .POP_N(POP_N)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush), .push_data(push_data),
    .push_num(push_num), .pop_num(pop_num), .pop_data(pop_data), .pop_valid(pop_valid),
    .count(count), .free_slots(free_slots), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain FIFO queue plus expected error pulses.
  logic [63:0] q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      int sz;
      bit pu, po;
      sz = q.size();
      pu = int'(push_num) <= DEPTH - sz;
      po = int'(pop_num) <= sz;
      m_ovf = !pu;
      m_unf = !po;
      if (po) for (int i = 0; i < int'(pop_num); i++) void'(q.pop_front());
      if (pu) for (int i = 0; i < int'(push_num); i++) q.push_back(push_data[i]);
    end
  end

  always @(negedge aclk) begin
    int sz;
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("free_slots", 64'(free_slots), 64'(DEPTH - sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
    for (int i = 0; i < POP_N; i++) begin
      chk("pop_valid", 64'(pop_valid[i]), 64'(sz > i));
      chk("pop_data", pop_data[i], (sz > i) ? q[i] : 64'h0);
    end
  end

  // Inputs change on the falling edge; outputs are then observed one falling edge later.
  task automatic drive(input int pn, input logic [63:0] base, input int popn, input bit fl);
    for (int i = 0; i < PUSH_N; i++)
      push_data[i] = (i < pn) ? base + 64'(i) : {$urandom, $urandom};
    push_num = 3'(pn);
    pop_num  = 2'(popn);
    flush    = fl;
    @(posedge aclk);
    @(negedge aclk);
    push_num = '0;
    pop_num  = '0;
    flush    = 1'b0;
  endtask

  initial begin
    logic [63:0] prev;
    repeat (2) @(negedge aclk);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_free", 64'(free_slots), 64'd16);
    aresetn = 1'b1;

    // 1: first push visible next cycle
    drive(4, 64'h10, 0, 0);
    chk("t1_count", 64'(count), 64'd4);
    chk("t1_free", 64'(free_slots), 64'd12);
    chk("t1_valid", 64'(pop_valid), 64'd3);
    chk("t1_lane0", pop_data[0], 64'h10);
    chk("t1_lane1", pop_data[1], 64'h11);

    // 2: fill, then overflow
    drive(4, 64'h14, 0, 0);
    drive(4, 64'h18, 0, 0);
    drive(4, 64'h1c, 0, 0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_free", 64'(free_slots), 64'd0);
    drive(1, 64'h99, 0, 0);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_count", 64'(count), 64'd16);
    chk("t2_head", pop_data[0], 64'h10);
    drive(0, 64'h0, 0, 0);
    chk("t2_ovf_pulse", 64'(overflow), 64'd0);

    // 3: wrap-around steady state at count 8
    repeat (4) drive(0, 64'h0, 2, 0);
    chk("t3_start", pop_data[0], 64'h18);
    prev = 64'h16;
    for (int c = 0; c < 40; c++) begin
      chk("t3_seq", pop_data[0], prev + 64'd2);
      prev = pop_data[0];
      drive(2, 64'h20 + 64'(2 * c), 2, 0);
      chk("t3_count", 64'(count), 64'd8);
    end

    // 4: underflow then drain
    repeat (3) drive(0, 64'h0, 2, 0);
    drive(0, 64'h0, 1, 0);
    chk("t4_count1", 64'(count), 64'd1);
    drive(0, 64'h0, 2, 0);
    chk("t4_unf", 64'(underflow), 64'd1);
    chk("t4_count", 64'(count), 64'd1);
    drive(0, 64'h0, 1, 0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_valid", 64'(pop_valid), 64'd0);
    chk("t4_data", pop_data[0], 64'h0);

    // 5: flush beats push/pop
    drive(4, 64'h100, 0, 0);
    drive(4, 64'h104, 0, 0);
    drive(2, 64'h108, 0, 0);
    chk("t5_count10", 64'(count), 64'd10);
    drive(3, 64'h200, 2, 1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_noerr", 64'({overflow, underflow}), 64'd0);
    drive(1, 64'h55, 0, 0);
    chk("t5_lane0", pop_data[0], 64'h55);

    // 6: pre-pop free space governs push
    drive(4, 64'h300, 0, 0);
    drive(4, 64'h304, 0, 0);
    drive(4, 64'h308, 0, 0);
    drive(1, 64'h30c, 0, 0);
    chk("t6_count14", 64'(count), 64'd14);
    drive(2, 64'h400, 2, 0);
    chk("t6_count", 64'(count), 64'd14);
    chk("t6_noovf", 64'(overflow), 64'd0);
    drive(3, 64'h500, 2, 0);
    chk("t6_ovf", 64'(overflow), 64'd1);
    chk("t6_count12", 64'(count), 64'd12);

    // Randomized traffic with rare flush and mid-run reset
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        #1 aresetn = 1'b0;
        #1 chk("rand_async_rst", 64'(count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
      end
      drive($urandom_range(0, 4), {$urandom, $urandom}, $urandom_range(0, 2),
            $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
